// File: rtl/fixedpoint_pkg.sv
// Shared types and helpers for the fixed-point datapath blocks.
// Holds the arbiter state encoding and the round-robin pick function.
package fixedpoint_pkg;

    localparam int MAX_REQUESTERS = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESPOND
    } sub_arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0] at or above ptr, wrapping past n-1 back to 0.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQUESTERS-1:0] valid,
                                         input logic [3:0]                ptr,
                                         input int                        n);
        rr_pick_t r;
        int       k;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_REQUESTERS; i++) begin
            k = (int'(ptr) + i) % n;
            if (i < n && !r.found && valid[k[3:0]]) begin
                r.found = 1'b1;
                r.idx   = k[3:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sub.sv
// Fixed-point subtractor: whole and fraction fields subtract independently,
// each wrapping in its own width; the result registers when calculate_en is high.
module sub #(
    parameter int wholeWidth    = 8,
    parameter int fractionWidth = 8
) (
    input  logic                                clock,
    input  logic                                calculate_en,
    input  logic [wholeWidth+fractionWidth-1:0] valueOne,
    input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
    output logic [wholeWidth+fractionWidth-1:0] difference
);

    localparam int W = wholeWidth + fractionWidth;

    logic [W-1:0]             difference_q;
    logic [W-1:0]             difference_d;
    logic [wholeWidth-1:0]    whole_diff;
    logic [fractionWidth-1:0] frac_diff;

    always_comb begin
        whole_diff   = valueOne[W-1:fractionWidth] - valueTwo[W-1:fractionWidth];
        frac_diff    = valueOne[fractionWidth-1:0] - valueTwo[fractionWidth-1:0];
        difference_d = {whole_diff, frac_diff};
    end

    always_ff @(posedge clock) begin
        if (calculate_en) begin
            difference_q <= difference_d;
        end
    end

    assign difference = difference_q;

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin front end that shares one sub instance among several clients,
// one operation in flight, with a backpressured tagged response.
module sub_arbiter
    import fixedpoint_pkg::*;
#(
    parameter int wholeWidth    = 8,
    parameter int fractionWidth = 8,
    parameter int numRequesters = 4,
    localparam int W            = wholeWidth + fractionWidth,
    localparam int idWidth      = $clog2(numRequesters)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [numRequesters-1:0]   req_valid,
    output logic [numRequesters-1:0]   req_ready,
    input  logic [numRequesters*W-1:0] req_value_one,
    input  logic [numRequesters*W-1:0] req_value_two,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [idWidth-1:0]         rsp_id,
    output logic [W-1:0]               rsp_difference,
    output logic                       busy
);

    if (numRequesters < 2 || numRequesters > MAX_REQUESTERS) begin : g_bad_requesters
        $error("sub_arbiter: numRequesters must be in 2..16");
    end

    sub_arb_state_t       state_q, state_d;
    logic [idWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [idWidth-1:0]   op_id_q, op_id_d;
    logic [W-1:0]         op_one_q, op_one_d;
    logic [W-1:0]         op_two_q, op_two_d;
    logic                 calculate_en;
    rr_pick_t             pick;
    logic [idWidth-1:0]   grant;
    logic [W-1:0]         one_sel;
    logic [W-1:0]         two_sel;

    always_comb begin
        pick    = rr_pick(MAX_REQUESTERS'(req_valid), 4'(rr_ptr_q), numRequesters);
        grant   = pick.idx[idWidth-1:0];
        one_sel = '0;
        two_sel = '0;
        for (int i = 0; i < numRequesters; i++) begin
            if (grant == idWidth'(i)) begin
                one_sel = req_value_one[i*W +: W];
                two_sel = req_value_two[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_id_d      = op_id_q;
        op_one_d     = op_one_q;
        op_two_d     = op_two_q;
        req_ready    = '0;
        rsp_valid    = 1'b0;
        calculate_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    req_ready = numRequesters'(1) << grant;
                    op_id_d   = grant;
                    op_one_d  = one_sel;
                    op_two_d  = two_sel;
                    rr_ptr_d  = (pick.idx == 4'(numRequesters - 1)) ? '0 : grant + 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                calculate_en = 1'b1;
                state_d      = CAPTURE;
            end
            CAPTURE: begin
                state_d = RESPOND;
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_id_q  <= '0;
            op_one_q <= '0;
            op_two_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_id_q  <= op_id_d;
            op_one_q <= op_one_d;
            op_two_q <= op_two_d;
        end
    end

    assign rsp_id = op_id_q;
    assign busy   = (state_q != IDLE);

    sub #(
        .wholeWidth   (wholeWidth),
        .fractionWidth(fractionWidth)
    ) u_sub (
        .clock       (clock),
        .calculate_en(calculate_en),
        .valueOne    (op_one_q),
        .valueTwo    (op_two_q),
        .difference  (rsp_difference)
    );

endmodule
